// File: rtl/fp16_output_arbiter_if.sv
// rtl/fp16_output_arbiter_if.sv - requester and result-bus signals of the FP16 output arbiter
interface fp16_output_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ-1:0]    req_sign;
    logic [NUM_REQ*5-1:0]  req_exponent;
    logic [NUM_REQ*18-1:0] req_mantissa;
    logic                  out_valid;
    logic                  out_ready;
    logic [15:0]           out_fp16;
    logic [ID_W-1:0]       out_id;

    modport master (
        output req_valid, req_sign, req_exponent, req_mantissa, out_ready,
        input  req_ready, out_valid, out_fp16, out_id
    );

    modport slave (
        input  req_valid, req_sign, req_exponent, req_mantissa, out_ready,
        output req_ready, out_valid, out_fp16, out_id
    );
endinterface

// File: rtl/fp16_output_arbiter.sv
// rtl/fp16_output_arbiter.sv - round-robin shared FP16 round/pack output stage
// Optional stall counter port enabled by FP16_OUT_ARB_STALL_CNT_EN.
module fp16_output_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    fp16_output_arbiter_if.slave bus
`ifdef FP16_OUT_ARB_STALL_CNT_EN
    ,
    output logic [15:0]          stall_cnt
`endif
);
    localparam int IDX_W = ID_W + 1;

    typedef enum logic {EMPTY, FULL} state_t;

    state_t             state;
    logic [ID_W-1:0]    rr_ptr;
    logic [ID_W-1:0]    id_q;
    logic [15:0]        fp16_q;
    logic               load_en;
    logic               found;
    logic [ID_W-1:0]    gnt_idx;
    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   scan_idx;
    logic [ID_W-1:0]    next_ptr;
    logic               sel_sign;
    logic [4:0]         sel_exp;
    logic [17:0]        sel_man;
    logic [10:0]        rnd;
    logic               ovf;
    logic [4:0]         pack_exp;
    logic [15:0]        packed_fp16;
    logic               unused_man_bits;

    assign load_en = (state == EMPTY) || bus.out_ready;

    // Scan rr_ptr, rr_ptr+1, ... with an explicit wrap so non-power-of-2 counts work.
    always_comb begin
        found    = 1'b0;
        gnt_idx  = '0;
        grant    = '0;
        scan_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = {1'b0, rr_ptr} + IDX_W'(k);
            if (scan_idx >= IDX_W'(NUM_REQ))
                scan_idx = scan_idx - IDX_W'(NUM_REQ);
            if (!found && bus.req_valid[scan_idx[ID_W-1:0]]) begin
                found   = 1'b1;
                gnt_idx = scan_idx[ID_W-1:0];
            end
        end
        if (found)
            grant[gnt_idx] = 1'b1;
    end

    assign bus.req_ready = (rst || !load_en) ? '0 : grant;
    assign next_ptr      = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);

    always_comb begin
        sel_sign = 1'b0;
        sel_exp  = '0;
        sel_man  = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (gnt_idx == ID_W'(j)) begin
                sel_sign = bus.req_sign[j];
                sel_exp  = bus.req_exponent[5*j +: 5];
                sel_man  = bus.req_mantissa[18*j +: 18];
            end
        end
    end

    // Round half up on bit 6; a carry out of the fraction bumps the exponent unless it is already 31.
    assign rnd             = {1'b0, sel_man[16:7]} + {10'd0, sel_man[6]};
    assign ovf             = rnd[10];
    assign pack_exp        = (ovf && sel_exp != 5'd31) ? sel_exp + 5'd1 : sel_exp;
    assign packed_fp16     = {sel_sign, pack_exp, rnd[9:0]};
    assign unused_man_bits = ^{sel_man[17], sel_man[5:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= EMPTY;
            fp16_q <= '0;
            id_q   <= '0;
            rr_ptr <= '0;
        end else if (load_en) begin
            if (found) begin
                state  <= FULL;
                fp16_q <= packed_fp16;
                id_q   <= gnt_idx;
                rr_ptr <= next_ptr;
            end else begin
                state  <= EMPTY;
            end
        end
    end

    assign bus.out_valid = (state == FULL);
    assign bus.out_fp16  = fp16_q;
    assign bus.out_id    = id_q;

`ifdef FP16_OUT_ARB_STALL_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cnt <= '0;
        else if (state == FULL && !bus.out_ready && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
    end
`endif
endmodule

// File: tb/tb_fp16_output_arbiter.sv
// tb/tb_fp16_output_arbiter.sv - table-driven and scoreboard bench for fp16_output_arbiter
module tb_fp16_output_arbiter;
    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    typedef struct {
        logic        s;
        logic [4:0]  e;
        logic [17:0] m;
        logic [15:0] exp_fp16;
    } vec_t;

    typedef struct {
        logic [15:0]     fp16;
        logic [ID_W-1:0] id;
    } sb_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fp16_output_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus();
`ifdef FP16_OUT_ARB_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    fp16_output_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef FP16_OUT_ARB_STALL_CNT_EN
        ,
        .stall_cnt(stall_cnt)
`endif
    );

    vec_t        vec[8];
    logic [15:0] cur_exp[NUM_REQ];
    sb_t         sb[$];
    int          n_vec  = 0;
    int          n_fail = 0;
    int          b_ids[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_req(input int i, input int k);
        bus.req_sign[i]            = vec[k].s;
        bus.req_exponent[5*i +: 5]  = vec[k].e;
        bus.req_mantissa[18*i +: 18] = vec[k].m;
        cur_exp[i]                 = vec[k].exp_fp16;
    endtask

    // One clock: at the falling edge check grants, retire an output transfer, record new grants.
    task automatic tick(input logic [3:0] exp_rdy);
        sb_t e;
        @(negedge clk);
        check("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
        if (bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL sb_underflow: got unexpected output id %0d expected none", bus.out_id);
            end else begin
                e = sb.pop_front();
                check("out_fp16", 32'(bus.out_fp16), 32'(e.fp16));
                check("out_id", 32'(bus.out_id), 32'(e.id));
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (bus.req_valid[i] && bus.req_ready[i]) begin
                e.fp16 = cur_exp[i];
                e.id   = ID_W'(i);
                sb.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec[0] = '{1'b0, 5'd15, 18'h00040, 16'h3C01};
        vec[1] = '{1'b0, 5'd15, 18'h1FFC0, 16'h4000};
        vec[2] = '{1'b1, 5'd31, 18'h1FFC0, 16'hFC00};
        vec[3] = '{1'b0, 5'd0,  18'h00000, 16'h0000};
        vec[4] = '{1'b1, 5'd10, 18'h00080, 16'hA801};
        vec[5] = '{1'b0, 5'd1,  18'h3FFFF, 16'h0800};
        vec[6] = '{1'b0, 5'd30, 18'h1FF80, 16'h7BFF};
        vec[7] = '{1'b0, 5'd16, 18'h0AAC0, 16'h4156};
        b_ids  = '{0, 1, 2, 3, 0, 1};

        rst           = 1'b1;
        bus.out_ready = 1'b0;
        bus.req_valid = 4'hF;
        for (int i = 0; i < NUM_REQ; i++) set_req(i, i);
        tick(4'b0000);
        tick(4'b0000);
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_out_fp16", 32'(bus.out_fp16), 0);
        check("rst_out_id", 32'(bus.out_id), 0);
`ifdef FP16_OUT_ARB_STALL_CNT_EN
        check("rst_stall_cnt", 32'(stall_cnt), 0);
`endif
        bus.req_valid = '0;
        rst           = 1'b0;

        // Pack table, one requester at a time, back to back at full throughput.
        for (int k = 0; k < 8; k++) begin
            set_req(k % 4, k);
            bus.req_valid = 4'(1 << (k % 4));
            bus.out_ready = 1'b1;
            tick(4'(1 << (k % 4)));
            check("tbl_out_valid", 32'(bus.out_valid), 1);
            check("tbl_out_id", 32'(bus.out_id), 32'(k % 4));
        end
        bus.req_valid = '0;
        tick(4'b0000);
        check("drain_out_valid", 32'(bus.out_valid), 0);

        // All requesters valid: strict rotation.
        for (int i = 0; i < NUM_REQ; i++) set_req(i, i);
        bus.req_valid = 4'hF;
        for (int n = 0; n < 6; n++) tick(4'(1 << b_ids[n]));

        // Back-pressure holds the result and blocks grants.
        bus.out_ready = 1'b0;
        for (int n = 0; n < 5; n++) begin
            tick(4'b0000);
            check("hold_out_id", 32'(bus.out_id), 1);
            check("hold_out_fp16", 32'(bus.out_fp16), 32'(vec[1].exp_fp16));
        end
`ifdef FP16_OUT_ARB_STALL_CNT_EN
        check("stall_cnt_5", 32'(stall_cnt), 5);
`endif
        bus.out_ready = 1'b1;
        tick(4'b0100);
        check("release_out_id", 32'(bus.out_id), 2);

        // rr_ptr=3 with requesters 2 and 3: grant 3 then 2, then go empty.
        bus.req_valid = 4'b1100;
        tick(4'b1000);
        tick(4'b0100);
        bus.req_valid = '0;
        tick(4'b0000);
        check("idle_out_valid", 32'(bus.out_valid), 0);

        // A lone requester is granted every cycle.
        bus.req_valid = 4'b0100;
        for (int n = 0; n < 3; n++) tick(4'b0100);
        bus.req_valid = '0;
        tick(4'b0000);
        check("lone_out_valid", 32'(bus.out_valid), 0);

        // EMPTY loads even without out_ready, then FULL stalls.
        bus.out_ready = 1'b0;
        bus.req_valid = 4'b0010;
        tick(4'b0010);
        bus.req_valid = 4'hF;
        tick(4'b0000);
        check("full_out_valid", 32'(bus.out_valid), 1);
`ifdef FP16_OUT_ARB_STALL_CNT_EN
        check("stall_cnt_6", 32'(stall_cnt), 6);
`endif

        // Asynchronous reset while FULL and stalled drops the held result.
        rst = 1'b1;
        #1;
        check("arst_out_valid", 32'(bus.out_valid), 0);
        check("arst_out_fp16", 32'(bus.out_fp16), 0);
        check("arst_out_id", 32'(bus.out_id), 0);
        check("arst_req_ready", 32'(bus.req_ready), 0);
`ifdef FP16_OUT_ARB_STALL_CNT_EN
        check("arst_stall_cnt", 32'(stall_cnt), 0);
`endif
        sb.delete();
        @(posedge clk);
        #1;
        rst           = 1'b0;
        bus.out_ready = 1'b1;
        bus.req_valid = 4'hF;
        tick(4'b0001);
        bus.req_valid = '0;
        tick(4'b0000);
        check("final_out_valid", 32'(bus.out_valid), 0);
        check("sb_empty", 32'(sb.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
